// File: rtl/ni_pkg.sv
// ni_pkg: shared types and helpers for the ni_tx network-interface transmitter.
//   state_t  : transmitter handshake states
//   rails_t  : four 1-of-4 rail vectors sized for the widest supported port
//   enc1of4  : maps a data word onto the four rail vectors
package ni_pkg;

    localparam int unsigned CW_DEFAULT = 16;
    localparam int unsigned DW_MAX     = 64;
    localparam int unsigned SCN_MAX    = DW_MAX / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRTZ,
        ST_EOF,
        ST_ERTZ
    } state_t;

    typedef struct packed {
        logic [SCN_MAX-1:0] r3;
        logic [SCN_MAX-1:0] r2;
        logic [SCN_MAX-1:0] r1;
        logic [SCN_MAX-1:0] r0;
    } rails_t;

    // One rail per 2-bit digit: digit value K raises bit j of rail K.
    function automatic rails_t enc1of4(input logic [DW_MAX-1:0] data);
        rails_t r;
        r = '0;
        for (int j = 0; j < int'(SCN_MAX); j++) begin
            case (data[2*j +: 2])
                2'd0:    r.r0[j] = 1'b1;
                2'd1:    r.r1[j] = 1'b1;
                2'd2:    r.r2[j] = 1'b1;
                default: r.r3[j] = 1'b1;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ni_tx_ack_sync.sv
// ack_sync: two-flop synchroniser for the router acknowledge.
//   clk, rst_n : clock, synchronous active-low reset (output resets to 0)
//   d          : asynchronous input
//   q          : synchronised output, two clk cycles after d
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ni_tx.sv
// ni_tx: clocked-to-asynchronous flit injector. Accepts DW-bit words over
// valid/ready, drives them as SCN 1-of-4 sub-channels (do0..do3) plus an eof
// rail (do4), and runs a four-phase return-to-zero handshake against doa.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : source handshake; in_data word, in_eof packet tail
//   do0..do3, do4       : registered data rails and eof rail
//   doa                 : router acknowledge (asynchronous to clk)
//   busy                : handshake in progress
//   pkt_cnt             : completed eof tokens, wraps
// Build option: define NI_TX_ACK_SYNC_EN to pass doa through a two-flop
// synchroniser; otherwise doa is used directly as a clk-synchronous ack.
module ni_tx
    import ni_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned SCN = DW / 2,
    parameter int unsigned CW  = CW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    input  logic           in_eof,
    output logic           in_ready,
    output logic [SCN-1:0] do0,
    output logic [SCN-1:0] do1,
    output logic [SCN-1:0] do2,
    output logic [SCN-1:0] do3,
    output logic           do4,
    input  logic           doa,
    output logic           busy,
    output logic [CW-1:0]  pkt_cnt
);

    state_t         state, state_next;
    logic           tail, tail_next;
    logic [CW-1:0]  cnt_next;
    logic [SCN-1:0] do0_next, do1_next, do2_next, do3_next;
    logic           do4_next;
    logic           ack_s;
    logic           settled;
    rails_t         enc_full;
    logic           unused_enc;

`ifdef NI_TX_ACK_SYNC_EN
    logic [1:0] settle;

    ack_sync u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (doa),
        .q     (ack_s)
    );

    // The synchroniser restarts at 0 after reset, so hold off acceptance until
    // it has sampled the live ack; a router still acking must not see a new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle <= 2'd0;
        end else if (settle != 2'd2) begin
            settle <= settle + 2'd1;
        end
    end

    assign settled = (settle == 2'd2);
`else
    assign ack_s   = doa;
    assign settled = 1'b1;
`endif

    // Encode at the widest width, keep the low SCN lanes.
    assign enc_full   = enc1of4(DW_MAX'(in_data));
    assign unused_enc = ^enc_full;

    assign in_ready = rst_n && settled && (state == ST_IDLE) && !ack_s;
    assign busy     = (state != ST_IDLE);

    // Next-state and next-rail logic.
    always_comb begin
        state_next = state;
        tail_next  = tail;
        cnt_next   = pkt_cnt;
        do0_next   = do0;
        do1_next   = do1;
        do2_next   = do2;
        do3_next   = do3;
        do4_next   = do4;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    tail_next  = in_eof;
                    do0_next   = enc_full.r0[SCN-1:0];
                    do1_next   = enc_full.r1[SCN-1:0];
                    do2_next   = enc_full.r2[SCN-1:0];
                    do3_next   = enc_full.r3[SCN-1:0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ack_s) begin
                    do0_next   = '0;
                    do1_next   = '0;
                    do2_next   = '0;
                    do3_next   = '0;
                    state_next = ST_DRTZ;
                end
            end
            ST_DRTZ: begin
                if (!ack_s) begin
                    if (tail) begin
                        do4_next   = 1'b1;
                        state_next = ST_EOF;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_EOF: begin
                if (ack_s) begin
                    do4_next   = 1'b0;
                    state_next = ST_ERTZ;
                end
            end
            ST_ERTZ: begin
                if (!ack_s) begin
                    cnt_next   = pkt_cnt + CW'(1);
                    tail_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                do0_next   = '0;
                do1_next   = '0;
                do2_next   = '0;
                do3_next   = '0;
                do4_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, rails, tail flag and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tail    <= 1'b0;
            pkt_cnt <= '0;
            do0     <= '0;
            do1     <= '0;
            do2     <= '0;
            do3     <= '0;
            do4     <= 1'b0;
        end else begin
            state   <= state_next;
            tail    <= tail_next;
            pkt_cnt <= cnt_next;
            do0     <= do0_next;
            do1     <= do1_next;
            do2     <= do2_next;
            do3     <= do3_next;
            do4     <= do4_next;
        end
    end

endmodule
